// File: rtl/bht_port_scheduler.sv
// bht_port_scheduler: arbitrates the single BHT RAM port between the init
// sweep, buffered counter updates and fetch-stage lookups. Lookups that hit a
// queued (not yet written) update are answered from the queue.
module bht_port_scheduler #(
  parameter int unsigned       IDX_W    = 13,
  parameter int unsigned       DATA_W   = 2,
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_req,
  output logic                        busy,
  input  logic                        lk_valid,
  input  logic [IDX_W-1:0]            lk_idx,
  output logic                        lk_ready,
  output logic                        lk_rvalid,
  output logic [DATA_W-1:0]           lk_data,
  input  logic                        up_valid,
  input  logic [IDX_W-1:0]            up_idx,
  input  logic [DATA_W-1:0]           up_data,
  output logic                        up_ready,
  output logic [$clog2(QDEPTH):0]     q_count,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [IDX_W-1:0]            ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata
);

  localparam int unsigned QA_W  = $clog2(QDEPTH);
  localparam int unsigned QC_W  = QA_W + 1;
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            r_state;
  logic              r_busy;
  logic [PTR_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_q_idx  [QDEPTH];
  logic [DATA_W-1:0] r_q_data [QDEPTH];
  logic [QA_W-1:0]   r_head;
  logic [QA_W-1:0]   r_tail;
  logic [QC_W-1:0]   r_count;
  logic              r_lk_rvalid;
  logic              r_fwd_hit;
  logic [DATA_W-1:0] r_fwd_data;
  logic [DATA_W-1:0] r_lk_data;

  logic              w_run;
  logic              w_full;
  logic              w_lk_accept;
  logic              w_enq;
  logic              w_deq;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic [DATA_W-1:0] w_lk_result;

  assign w_run     = (r_state == S_RUN) && !rst;
  assign w_full    = (r_count == QC_W'(QDEPTH));
  assign w_ptr_nxt = r_ptr + PTR_W'(1);

  assign lk_ready  = w_run && !w_full;
  assign up_ready  = w_run && !w_full;
  assign q_count   = r_count;
  assign busy      = r_busy;

  assign w_lk_accept = lk_valid && lk_ready;
  assign w_enq       = up_valid && up_ready && !clr_req;
  // A clearing cycle never drains the queue: its contents are being discarded.
  assign w_deq       = w_run && !clr_req && (r_count != '0) && !w_lk_accept;

  // RAM port mux: sweep, else queue-head write, else lookup read.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!rst) begin
      if (r_state == S_INIT) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = r_ptr[IDX_W-1:0];
        ram_wdata = INIT_VAL;
      end else if (w_deq) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = r_q_idx[r_head];
        ram_wdata = r_q_data[r_head];
      end else if (w_lk_accept) begin
        ram_en    = 1'b1;
        ram_addr  = lk_idx;
      end
    end
  end

  // Youngest matching pending update wins: scan oldest to newest, then the same-cycle enqueue.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if ((QC_W'(i) < r_count) && (r_q_idx[r_head + QA_W'(i)] == lk_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_q_data[r_head + QA_W'(i)];
      end
    end
    if (w_enq && (up_idx == lk_idx)) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = up_data;
    end
  end

  // Sweep / run control, queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_busy  <= 1'b1;
      r_ptr   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (clr_req) begin
            r_ptr <= '0;
          end else if (w_ptr_nxt[IDX_W]) begin
            r_state <= S_RUN;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
          end else begin
            r_ptr <= w_ptr_nxt;
          end
        end
        S_RUN: begin
          if (clr_req) begin
            r_state <= S_INIT;
            r_busy  <= 1'b1;
            r_ptr   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
          end else begin
            if (w_enq) r_tail <= r_tail + QA_W'(1);
            if (w_deq) r_head <= r_head + QA_W'(1);
            case ({w_enq, w_deq})
              2'b10:   r_count <= r_count + QC_W'(1);
              2'b01:   r_count <= r_count - QC_W'(1);
              default: r_count <= r_count;
            endcase
          end
        end
      endcase
    end
  end

  // Update queue storage.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_idx[r_tail]  <= up_idx;
      r_q_data[r_tail] <= up_data;
    end
  end

  // Lookup return pipeline; the RAM answers one cycle after the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lk_rvalid <= 1'b0;
      r_fwd_hit   <= 1'b0;
      r_fwd_data  <= '0;
      r_lk_data   <= '0;
    end else begin
      r_lk_rvalid <= w_lk_accept;
      r_fwd_hit   <= w_fwd_hit;
      r_fwd_data  <= w_fwd_data;
      if (r_lk_rvalid) r_lk_data <= w_lk_result;
    end
  end

  assign w_lk_result = r_fwd_hit ? r_fwd_data : ram_rdata;
  assign lk_rvalid   = r_lk_rvalid;
  assign lk_data     = r_lk_rvalid ? w_lk_result : r_lk_data;

endmodule

// File: tb/tb_bht_port_scheduler.sv
// Bench for bht_port_scheduler (IDX_W=4, QDEPTH=4): directed scenarios plus a
// randomized phase, checked against a table/queue reference model and a RAM model.
module tb_bht_port_scheduler;

  localparam logic [1:0] INIT = 2'b01;

  logic       clk = 1'b0;
  logic       rst, clr_req, busy;
  logic       lk_valid, lk_ready, lk_rvalid;
  logic [3:0] lk_idx;
  logic [1:0] lk_data;
  logic       up_valid, up_ready;
  logic [3:0] up_idx;
  logic [1:0] up_data;
  logic [2:0] q_count;
  logic       ram_en, ram_we;
  logic [3:0] ram_addr;
  logic [1:0] ram_wdata;
  logic [1:0] ram_rdata;

  bht_port_scheduler #(.IDX_W(4), .DATA_W(2), .QDEPTH(4), .INIT_VAL(INIT)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_ready(lk_ready),
    .lk_rvalid(lk_rvalid), .lk_data(lk_data),
    .up_valid(up_valid), .up_idx(up_idx), .up_data(up_data), .up_ready(up_ready),
    .q_count(q_count),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM macro model; the poke port lets the bench seed a value.
  logic [1:0] mem [16];
  logic       poke_en;
  logic [3:0] poke_addr;
  logic [1:0] poke_data;
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct packed { logic [3:0] idx; logic [1:0] data; } upd_t;

  int         ntests = 0;
  int         nfail  = 0;
  logic [1:0] ref_tbl [16];
  upd_t       m_q [$];
  logic       exp_rv;
  logic [1:0] exp_rd;
  logic [1:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rv_check();
    if (exp_rv) begin
      chk("lk_rvalid", 32'(lk_rvalid), 32'd1);
      chk("lk_data", 32'(lk_data), 32'(exp_rd));
      last_data = exp_rd;
    end else begin
      chk("lk_rvalid_idle", 32'(lk_rvalid), 32'd0);
      chk("lk_data_hold", 32'(lk_data), 32'(last_data));
    end
    exp_rv = 1'b0;
  endtask

  // Checks n sweep cycles starting at address 0; a full sweep resets the model.
  task automatic check_sweep(input bit hold, input int n);
    for (int k = 0; k < n; k++) begin
      clr_req  = 1'b0;
      lk_valid = hold ? 1'($urandom_range(0, 1)) : 1'b0;
      up_valid = hold ? 1'($urandom_range(0, 1)) : 1'b0;
      lk_idx   = 4'($urandom);
      up_idx   = 4'($urandom);
      up_data  = 2'($urandom);
      #4;
      rv_check();
      chk("sweep_busy", 32'(busy), 32'd1);
      chk("sweep_en_we", 32'({ram_en, ram_we}), 32'd3);
      chk("sweep_addr", 32'(ram_addr), 32'(k));
      chk("sweep_wdata", 32'(ram_wdata), 32'(INIT));
      chk("sweep_lk_ready", 32'(lk_ready), 32'd0);
      chk("sweep_up_ready", 32'(up_ready), 32'd0);
      chk("sweep_q_count", 32'(q_count), 32'd0);
      @(posedge clk); #1;
    end
    if (n == 16) begin
      for (int i = 0; i < 16; i++) ref_tbl[i] = INIT;
      m_q.delete();
    end
  endtask

  task automatic run_cycle(input logic lkv, input logic [3:0] lki,
                           input logic upv, input logic [3:0] upi, input logic [1:0] upd);
    bit   full;
    upd_t h;
    clr_req = 1'b0; lk_valid = lkv; lk_idx = lki;
    up_valid = upv; up_idx = upi; up_data = upd;
    #4;
    rv_check();
    full = (m_q.size() == 4);
    chk("busy", 32'(busy), 32'd0);
    chk("q_count", 32'(q_count), 32'(m_q.size()));
    chk("lk_ready", 32'(lk_ready), 32'(!full));
    chk("up_ready", 32'(up_ready), 32'(!full));
    if (full || (!lkv && m_q.size() > 0)) begin
      h = m_q.pop_front();
      chk("wr_en_we", 32'({ram_en, ram_we}), 32'd3);
      chk("wr_addr", 32'(ram_addr), 32'(h.idx));
      chk("wr_data", 32'(ram_wdata), 32'(h.data));
    end else if (lkv) begin
      chk("rd_en_we", 32'({ram_en, ram_we}), 32'd2);
      chk("rd_addr", 32'(ram_addr), 32'(lki));
    end else begin
      chk("idle_en", 32'(ram_en), 32'd0);
    end
    if (upv && !full) begin
      m_q.push_back(upd_t'({upi, upd}));
      ref_tbl[upi] = upd;
    end
    if (lkv && !full) begin
      exp_rv = 1'b1;
      exp_rd = ref_tbl[lki];
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", ntests);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr_req = 1'b0; lk_valid = 1'b0; lk_idx = '0;
    up_valid = 1'b0; up_idx = '0; up_data = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    exp_rv = 1'b0; exp_rd = '0; last_data = '0;
    for (int i = 0; i < 16; i++) ref_tbl[i] = INIT;

    // Reset: RAM port quiet while rst is high
    @(posedge clk); #1;
    #4;
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. Full sweep from reset, idle inputs; then RUN with up_ready=1
    check_sweep(1'b0, 16);
    run_cycle(1'b0, 4'd0, 1'b0, 4'd0, 2'd0);

    // 2. Lookup idx 5 with RAM holding 2'b11
    poke_en = 1'b1; poke_addr = 4'd5; poke_data = 2'b11;
    run_cycle(1'b0, 4'd0, 1'b0, 4'd0, 2'd0);
    poke_en = 1'b0;
    ref_tbl[5] = 2'b11;
    run_cycle(1'b1, 4'd5, 1'b0, 4'd0, 2'd0);
    run_cycle(1'b0, 4'd0, 1'b0, 4'd0, 2'd0);
    run_cycle(1'b0, 4'd0, 1'b0, 4'd0, 2'd0);

    // 3. Two updates to idx 5 with lookup held; fill queue; forced head write
    run_cycle(1'b1, 4'd5, 1'b1, 4'd5, 2'b10);
    run_cycle(1'b1, 4'd5, 1'b1, 4'd5, 2'b01);
    run_cycle(1'b1, 4'd5, 1'b1, 4'd7, 2'b11);
    run_cycle(1'b1, 4'd5, 1'b1, 4'd9, 2'b00);
    run_cycle(1'b1, 4'd5, 1'b0, 4'd0, 2'd0);
    run_cycle(1'b1, 4'd5, 1'b0, 4'd0, 2'd0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 4'd0, 1'b0, 4'd0, 2'd0);
    run_cycle(1'b1, 4'd5, 1'b0, 4'd0, 2'd0);
    run_cycle(1'b0, 4'd0, 1'b0, 4'd0, 2'd0);

    // 4. Four updates with lookup held; update offered while full; drain order
    for (int i = 1; i <= 4; i++) run_cycle(1'b1, 4'd2, 1'b1, 4'(i), 2'(i));
    run_cycle(1'b1, 4'd2, 1'b1, 4'd11, 2'b11);
    run_cycle(1'b1, 4'd2, 1'b1, 4'd12, 2'b10);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 4'd0, 1'b0, 4'd0, 2'd0);

    // 5. clr_req with three queued updates and a lookup in the same cycle
    for (int i = 1; i <= 3; i++) run_cycle(1'b1, 4'd8, 1'b1, 4'(i), 2'(~i));
    clr_req = 1'b1; lk_valid = 1'b1; lk_idx = 4'd12;
    up_valid = 1'b1; up_idx = 4'd12; up_data = 2'b10;
    #4;
    rv_check();
    chk("clr_q_count", 32'(q_count), 32'd3);
    chk("clr_lk_ready", 32'(lk_ready), 32'd1);
    chk("clr_no_write", 32'({ram_en, ram_we}), 32'd2);
    chk("clr_rd_addr", 32'(ram_addr), 32'd12);
    exp_rv = 1'b1; exp_rd = ref_tbl[12];
    @(posedge clk); #1;
    check_sweep(1'b1, 16);
    for (int i = 0; i < 16; i++) chk("mem_after_clr", 32'(mem[i]), 32'(INIT));
    run_cycle(1'b0, 4'd0, 1'b0, 4'd0, 2'd0);

    // clr_req during the sweep restarts at index 0
    clr_req = 1'b1;
    #4;
    rv_check();
    chk("clr_run_lk_ready", 32'(lk_ready), 32'd1);
    @(posedge clk); #1;
    check_sweep(1'b1, 5);
    clr_req = 1'b1; lk_valid = 1'b0; up_valid = 1'b0;
    #4;
    chk("clr_init_addr", 32'(ram_addr), 32'd5);
    @(posedge clk); #1;
    check_sweep(1'b1, 16);

    // 6. rst at sweep index 9, with a returned lookup value in lk_data
    run_cycle(1'b1, 4'd3, 1'b0, 4'd0, 2'd0);
    clr_req = 1'b1; lk_valid = 1'b0;
    #4;
    rv_check();
    @(posedge clk); #1;
    check_sweep(1'b1, 9);
    clr_req = 1'b0; rst = 1'b1;
    #4;
    chk("rst_mid_en", 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; last_data = '0; exp_rv = 1'b0;
    check_sweep(1'b1, 16);

    // Randomized traffic, biased toward a few indices to exercise forwarding
    for (int n = 0; n < 400; n++) begin
      logic [3:0] li, ui;
      li = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      ui = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      run_cycle(1'($urandom_range(0, 1)), li, ($urandom_range(0, 9) < 6), ui, 2'($urandom));
    end
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 4'd0, 1'b0, 4'd0, 2'd0);
    for (int i = 0; i < 16; i++) chk("mem_final", 32'(mem[i]), 32'(ref_tbl[i]));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
